// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and a
// long-latency unit whose results queue in a small FIFO; a starvation guard forces drains.
module rf_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_stall,
    input  logic        i_ll_issue,
    input  logic [4:0]  i_ll_issue_rd,
    input  logic        i_ll_valid,
    output logic        o_ll_ready,
    input  logic [4:0]  i_ll_rd,
    input  logic [31:0] i_ll_data,
    output logic [31:0] o_ll_pending,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_rd,
    output logic [31:0] o_rf_data
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ll_ent_t;

    ll_ent_t          mem [FIFO_DEPTH];
    ll_ent_t          head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt, starve_nxt;
    logic [31:0]      pending_nxt;
    logic             empty, full, push, pop, wb_claim, wb_grant;

    assign head       = mem[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign o_ll_ready = !full;
    assign push       = i_ll_valid && !full;
    assign o_wb_stall = (starve_cnt == STV_W'(STARVE_LIMIT)) && !empty;

    // rd=0 from WB never claims the port, so a queued LL result can use the slot
    assign wb_claim = i_wb_valid && (i_wb_rd != 5'd0);
    assign pop      = !empty && (o_wb_stall || !wb_claim);
    assign wb_grant = wb_claim && !o_wb_stall;

    always_comb begin
        starve_nxt = starve_cnt;
        if (empty || pop)
            starve_nxt = '0;
        else if (starve_cnt != STV_W'(STARVE_LIMIT))
            starve_nxt = starve_cnt + STV_W'(1);
    end

    // set is applied after clear so a same-cycle reissue keeps the bit
    always_comb begin
        pending_nxt = o_ll_pending;
        if (pop)
            pending_nxt[head.rd] = 1'b0;
        if (i_ll_issue && (i_ll_issue_rd != 5'd0))
            pending_nxt[i_ll_issue_rd] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= '{rd: i_ll_rd, data: i_ll_data};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            o_ll_pending <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            starve_cnt   <= starve_nxt;
            o_ll_pending <= pending_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_rf_we   <= 1'b0;
            o_rf_rd   <= '0;
            o_rf_data <= '0;
        end else begin
            o_rf_we <= wb_grant || (pop && (head.rd != 5'd0));
            if (wb_grant) begin
                o_rf_rd   <= i_wb_rd;
                o_rf_data <= i_wb_data;
            end else if (pop) begin
                o_rf_rd   <= head.rd;
                o_rf_data <= head.data;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed + random checks of rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        o_wb_stall;
    logic        i_ll_issue;
    logic [4:0]  i_ll_issue_rd;
    logic        i_ll_valid;
    logic        o_ll_ready;
    logic [4:0]  i_ll_rd;
    logic [31:0] i_ll_data;
    logic [31:0] o_ll_pending;
    logic        o_rf_we;
    logic [4:0]  o_rf_rd;
    logic [31:0] o_rf_data;

    always #5 i_clk = ~i_clk;

    rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .o_wb_stall(o_wb_stall),
        .i_ll_issue(i_ll_issue), .i_ll_issue_rd(i_ll_issue_rd),
        .i_ll_valid(i_ll_valid), .o_ll_ready(o_ll_ready),
        .i_ll_rd(i_ll_rd), .i_ll_data(i_ll_data),
        .o_ll_pending(o_ll_pending),
        .o_rf_we(o_rf_we), .o_rf_rd(o_rf_rd), .o_rf_data(o_rf_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          starve;
    logic [31:0] pend;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    logic        acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_data = '0;
        i_ll_issue = 1'b0; i_ll_issue_rd = '0;
        i_ll_valid = 1'b0; i_ll_rd = '0; i_ll_data = '0;
        @(posedge i_clk); #1;
        q.delete();
        starve = 0;
        pend   = '0;
        exp_we = 1'b0;
        chk("rst_we",      32'(o_rf_we), 32'd0);
        chk("rst_rd",      32'(o_rf_rd), 32'd0);
        chk("rst_data",    o_rf_data, 32'd0);
        chk("rst_pending", o_ll_pending, 32'd0);
        chk("rst_stall",   32'(o_wb_stall), 32'd0);
        chk("rst_ready",   32'(o_ll_ready), 32'd1);
        i_rstn = 1'b1;
    endtask

    // One clock: drive inputs, check the combinational handshakes, then the registered outputs.
    task automatic cyc(input logic wbv, input logic [4:0] wrd, input logic [31:0] wdata,
                       input logic iss, input logic [4:0] ird,
                       input logic llv, input logic [4:0] lrd, input logic [31:0] ldata,
                       output logic accepted);
        logic m_stall, m_ready, popped;
        int   had;
        ent_t h;
        i_rstn = 1'b1;
        i_wb_valid = wbv; i_wb_rd = wrd; i_wb_data = wdata;
        i_ll_issue = iss; i_ll_issue_rd = ird;
        i_ll_valid = llv; i_ll_rd = lrd; i_ll_data = ldata;
        #2;
        had     = q.size();
        m_stall = (starve == LIMIT) && (had > 0);
        m_ready = had < DEPTH;
        chk("wb_stall", 32'(o_wb_stall), 32'(m_stall));
        chk("ll_ready", 32'(o_ll_ready), 32'(m_ready));
        popped = 1'b0;
        exp_we = 1'b0;
        if (m_stall || (had > 0 && !(wbv && wrd != 0))) begin
            h        = q.pop_front();
            popped   = 1'b1;
            exp_we   = (h.rd != 0);
            exp_rd   = h.rd;
            exp_data = h.data;
            pend[h.rd] = 1'b0;
        end else if (wbv && wrd != 0) begin
            exp_we   = 1'b1;
            exp_rd   = wrd;
            exp_data = wdata;
        end
        if (had == 0 || popped) starve = 0;
        else if (starve < LIMIT) starve = starve + 1;
        if (iss && ird != 0) pend[ird] = 1'b1;
        accepted = llv && m_ready;
        if (accepted) q.push_back('{rd: lrd, data: ldata});
        @(posedge i_clk); #1;
        chk("rf_we", 32'(o_rf_we), 32'(exp_we));
        if (exp_we) begin
            chk("rf_rd",   32'(o_rf_rd), 32'(exp_rd));
            chk("rf_data", o_rf_data, exp_data);
        end
        chk("pending", o_ll_pending, pend);
    endtask

    task automatic idle();
        logic a;
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, a);
    endtask

    initial begin
        int idx;
        do_reset();

        // WB write goes straight through
        cyc(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, acc);
        chk("t1_we", 32'(o_rf_we), 32'd1);
        chk("t1_data", o_rf_data, 32'hA5A5A5A5);

        // LL issue, push, pop with WB idle
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, acc);
        chk("t2_bit7_set", 32'(o_ll_pending[7]), 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h1234, acc);
        chk("t2_no_bypass", 32'(o_rf_we), 32'd0);
        idle();
        chk("t2_rd7", 32'(o_rf_rd), 32'd7);
        chk("t2_bit7_clr", 32'(o_ll_pending[7]), 32'd0);
        idle();

        // WB saturated with one LL entry queued -> starvation stall
        cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 1'b1, 5'd3, 32'hBEEF, acc);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 5'(i + 2), 32'(i), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, acc);
        chk("t3_pending_clr", 32'(o_ll_pending[3]), 32'd0);

        // Three pushes into a 2-deep FIFO under WB saturation
        idx = 0;
        for (int n = 0; n < 40 && idx < 3; n++) begin
            cyc(1'b1, 5'd1, 32'(n), 1'b0, 5'd0, 1'b1, 5'(10 + idx), 32'h100 + 32'(idx), acc);
            if (acc) idx++;
        end
        chk("t4_all_pushed", 32'(idx), 32'd3);
        for (int n = 0; n < 40 && q.size() > 0; n++)
            cyc(1'b1, 5'd2, 32'(n), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, acc);
        chk("t4_drained_ready", 32'(o_ll_ready), 32'd1);
        idle();

        // Pop of rd=9 collides with a new issue to rd=9
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, acc);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99, acc);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, acc);
        chk("t5_bit9_kept", 32'(o_ll_pending[9]), 32'd1);

        // rd=0 on both paths never writes
        cyc(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, acc);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hF00D, acc);
        repeat (3) idle();

        // Reset with two queued entries discards them
        cyc(1'b1, 5'd1, 32'd1, 1'b1, 5'd20, 1'b1, 5'd20, 32'h20, acc);
        cyc(1'b1, 5'd2, 32'd2, 1'b1, 5'd21, 1'b1, 5'd21, 32'h21, acc);
        cyc(1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, acc);
        do_reset();
        repeat (4) idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
                $urandom_range(0, 2) == 0,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
                acc);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
